fib_sram_ctrl: RTL and testbench

Fibonacci table generator and read-back controller sitting directly upstream of the single-port sram block. On a start pulse it computes the first N Fibonacci terms (F0=0, F1=1, Fk=Fk-1+Fk-2 mod 2^DATA_WIDTH) and writes them to SRAM addresses 0..N-1, one per cycle. It then serves single-term read requests through the same SRAM port with a valid handshake.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_step.sv | 49 ++++
 rtl/fib_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_fib_sram_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci table generator.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GEN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_RD_RESP = 2'd3
  } fib_state_t;

  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_step.sv
// Fibonacci recurrence datapath: prev/curr term registers, adder and sticky wrap flag.
module fib_step
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] term,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] curr_q;
  logic                  prev_c_q;
  logic                  curr_c_q;
  logic [DATA_WIDTH:0]   sum;

  assign sum = {1'b0, prev_q} + {1'b0, curr_q};

  // Each term carries its own wrap flag, so overflow only reflects terms
  // that were actually emitted, not look-ahead sums beyond the table end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= DATA_WIDTH'(FIB_SEED0);
      curr_q   <= DATA_WIDTH'(FIB_SEED1);
      prev_c_q <= 1'b0;
      curr_c_q <= 1'b0;
      overflow <= 1'b0;
    end else if (init) begin
      prev_q   <= DATA_WIDTH'(FIB_SEED0);
      curr_q   <= DATA_WIDTH'(FIB_SEED1);
      prev_c_q <= 1'b0;
      curr_c_q <= 1'b0;
      overflow <= 1'b0;
    end else if (advance) begin
      prev_q   <= curr_q;
      curr_q   <= sum[DATA_WIDTH-1:0];
      prev_c_q <= curr_c_q;
      curr_c_q <= sum[DATA_WIDTH];
      if (prev_c_q) overflow <= 1'b1;
    end
  end

  assign term = prev_q;

endmodule

// File: rtl/fib_sram_ctrl.sv
// Fibonacci table generator writing terms into a single-port SRAM and serving
// single-term reads back through the same port.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting; accepts start or a read request
//   ST_GEN     | writing one term per cycle to addresses 0..Nc-1
//   ST_DONE    | one-cycle done pulse after the last write
//   ST_RD_RESP | read response strobe (SRAM data or out-of-bounds zero)
module fib_sram_ctrl
  import fib_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_terms,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   table_len,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_oob,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_WIDTH);

  fib_state_t state_q, state_d;
  logic [CW-1:0] remain_q, remain_d;
  logic [CW-1:0] table_len_q, table_len_d;
  logic          oob_q, oob_d;
  logic [CW-1:0] nc;
  logic          gen_init;
  logic          gen_adv;
  logic [DATA_WIDTH-1:0] term;

  assign nc = (num_terms > DEPTH) ? DEPTH : num_terms;

  fib_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fib_step (
    .clk      (clk),
    .rst      (rst),
    .init     (gen_init),
    .advance  (gen_adv),
    .term     (term),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      table_len_q <= '0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      table_len_q <= table_len_d;
      oob_q       <= oob_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    table_len_d = table_len_q;
    oob_d       = oob_q;
    gen_init    = 1'b0;
    gen_adv     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rd_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    rd_oob      = 1'b0;
    sram_we     = 1'b0;
    sram_oe     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        // rst gates the combinational read path so nothing reaches the SRAM
        // while the controller is held in reset.
        rd_ready = !start && !rst;
        if (start) begin
          gen_init    = 1'b1;
          remain_d    = nc;
          table_len_d = '0;
          state_d     = (nc == '0) ? ST_DONE : ST_GEN;
        end else if (rd_req && !rst) begin
          oob_d = (rd_addr >= table_len_q);
          if (rd_addr < table_len_q) begin
            sram_oe   = 1'b1;
            sram_addr = rd_addr[ADDR_WIDTH-1:0];
          end
          state_d = ST_RD_RESP;
        end
      end

      ST_GEN: begin
        busy        = 1'b1;
        sram_we     = 1'b1;
        sram_addr   = table_len_q[ADDR_WIDTH-1:0];
        sram_wdata  = term;
        gen_adv     = 1'b1;
        table_len_d = table_len_q + CW'(1);
        remain_d    = remain_q - CW'(1);
        if (remain_q == CW'(1)) state_d = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      ST_RD_RESP: begin
        rd_valid = 1'b1;
        rd_oob   = oob_q;
        rd_data  = oob_q ? '0 : sram_rdata;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign table_len = table_len_q;

endmodule

// File: tb/tb_fib_sram_ctrl.sv
// Self-checking bench for fib_sram_ctrl: directed read vectors, hand-written
// corner sequences and randomized generate/read rounds against a plain model.
module tb_fib_sram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_terms;
  logic          busy, done, overflow;
  logic [CW-1:0] table_len;
  logic          rd_req;
  logic [CW-1:0] rd_addr;
  logic          rd_ready, rd_valid, rd_oob;
  logic [DW-1:0] rd_data;
  logic          sram_we, sram_oe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  fib_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_terms  (num_terms),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .table_len  (table_len),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_oob     (rd_oob),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Registered-output single-port SRAM.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_oe) sram_rdata <= mem[sram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int model_term [DEPTH];
  int model_len  = 0;
  int model_ovf  = 0;

  typedef struct {
    int n;
    int addr;
    int exp_data;
    int exp_oob;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // True (unbounded) Fibonacci values; a stored term wraps when its true value
  // does not fit in DW bits.
  task automatic build_model(input int n);
    int a = 0;
    int b = 1;
    int t;
    model_len = (n > DEPTH) ? DEPTH : n;
    model_ovf = 0;
    for (int k = 0; k < model_len; k++) begin
      model_term[k] = a % (1 << DW);
      if (a >= (1 << DW)) model_ovf = 1;
      t = a + b;
      a = b;
      b = t;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_overflow"},  int'(overflow), 0);
    check({tag, "_table_len"}, int'(table_len), 0);
    check({tag, "_rd_valid"},  int'(rd_valid), 0);
    check({tag, "_rd_oob"},    int'(rd_oob), 0);
    check({tag, "_rd_data"},   int'(rd_data), 0);
    check({tag, "_sram_we"},   int'(sram_we), 0);
    check({tag, "_sram_oe"},   int'(sram_oe), 0);
  endtask

  // Pulse start with N, optionally with a simultaneous rd_req and/or a stray
  // start two cycles into generation, then check the whole write sequence.
  task automatic run_gen(input int n, input bit with_rd, input bit poke_start);
    int cyc_done = -1;
    int nw = 0;
    int saw_rd_valid = 0;
    int saw_we_oe = 0;
    build_model(n);
    @(negedge clk);
    start = 1'b1; num_terms = CW'(n); rd_req = with_rd; rd_addr = '0;
    #1;
    check("rd_ready_with_start", int'(rd_ready), 0);
    check("no_oe_with_start", int'(sram_oe), 0);
    @(negedge clk);
    start = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (poke_start && c == 2) begin
        start = 1'b1; num_terms = CW'(3);
      end else begin
        start = 1'b0;
      end
      #1;
      if (rd_valid) saw_rd_valid = 1;
      if (sram_we && sram_oe) saw_we_oe = 1;
      if (sram_we) begin
        if (nw < DEPTH) begin
          check("wr_addr", int'(sram_addr), nw);
          check("wr_data", int'(sram_wdata), model_term[nw]);
          check("busy_gen", int'(busy), 1);
        end
        nw++;
      end
      if (done) begin
        cyc_done = c;
        check("busy_in_done", int'(busy), 0);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", int'(cyc_done >= 0), 1);
    check("write_count", nw, model_len);
    check("done_cycle", cyc_done, model_len);
    check("no_rd_valid_in_gen", saw_rd_valid, 0);
    check("no_we_oe_overlap", saw_we_oe, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", int'(done), 0);
    check("table_len", int'(table_len), model_len);
    check("overflow", int'(overflow), model_ovf);
  endtask

  task automatic do_read(input int addr, input int exp_data, input int exp_oob, input string tag);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = CW'(addr);
    #1;
    check({tag, "_ready"}, int'(rd_ready), 1);
    check({tag, "_oe"}, int'(sram_oe), exp_oob ? 0 : 1);
    if (!exp_oob) check({tag, "_sram_addr"}, int'(sram_addr), addr);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    check({tag, "_valid"}, int'(rd_valid), 1);
    check({tag, "_data"}, int'(rd_data), exp_data);
    check({tag, "_oob"}, int'(rd_oob), exp_oob);
    check({tag, "_ready_resp"}, int'(rd_ready), 0);
    @(negedge clk);
    #1;
    check({tag, "_valid_once"}, int'(rd_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int a;
    int n;

    vecs[0]  = '{5, 0, 0, 0};
    vecs[1]  = '{5, 1, 1, 0};
    vecs[2]  = '{5, 2, 1, 0};
    vecs[3]  = '{5, 3, 2, 0};
    vecs[4]  = '{5, 4, 3, 0};
    vecs[5]  = '{5, 7, 0, 1};
    vecs[6]  = '{5, 5, 0, 1};
    vecs[7]  = '{16, 15, 98, 0};
    vecs[8]  = '{16, 14, 121, 0};
    vecs[9]  = '{16, 13, 233, 0};
    vecs[10] = '{16, 16, 0, 1};
    vecs[11] = '{0, 0, 0, 1};

    rst = 1'b1; start = 1'b0; num_terms = '0; rd_req = 1'b0; rd_addr = '0;
    #6;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i == 0 || vecs[i].n != vecs[i-1].n) run_gen(vecs[i].n, 1'b0, 1'b0);
      do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_oob, "vec_rd");
    end

    // Clamp, start-with-read priority, start ignored during generation.
    run_gen(31, 1'b0, 1'b0);
    check("clamp_len", int'(table_len), 16);
    run_gen(4, 1'b1, 1'b0);
    run_gen(16, 1'b0, 1'b1);
    check("poke_overflow", int'(overflow), 1);

    // Reset in the middle of a 16-term run, during the write to address 6.
    @(negedge clk);
    start = 1'b1; num_terms = CW'(16);
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (sram_we && sram_addr == AW'(6)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached_write6", found, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_gen_rst");
    @(negedge clk);
    rst = 1'b0;
    do_read(0, 0, 1, "post_rst_rd");
    run_gen(3, 1'b0, 1'b0);
    do_read(2, 1, 0, "post_rst_rd2");
    do_read(3, 0, 1, "post_rst_rd3");

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(0, 31));
      run_gen(n, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) begin
        a = int'($urandom_range(0, 20));
        do_read(a, (a < model_len) ? model_term[a] : 0, (a >= model_len) ? 1 : 0, "rand_rd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
